// File: rtl/insn_prefetch_buffer.sv
// rtl/insn_prefetch_buffer.sv - sequential instruction prefetch FIFO with redirect flush
// Head address is implicit (exp_addr); pushed words are always consecutive.
module insn_prefetch_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              pc_in,
    input  logic                     insn_take,
    output logic [31:0]              insn_out,
    output logic                     insn_valid,
    output logic                     mem_req,
    output logic [31:0]              mem_addr,
    input  logic                     mem_ack,
    input  logic [31:0]              mem_rdata,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, FILL, FULL, DISCARD} state_t;

    state_t         state, state_next;
    logic [31:0]    data_q [DEPTH];
    logic [AW-1:0]  rd_ptr, wr_ptr, rd_ptr_next, wr_ptr_next;
    logic [CW-1:0]  count_next;
    logic [31:0]    exp_addr, fetch_addr, exp_addr_next, fetch_addr_next, mem_addr_next;
    logic           req_next;
    logic           redirect, push, pop;

    assign redirect   = (pc_in != exp_addr);
    assign insn_valid = (fifo_count != '0) && !redirect;
    assign insn_out   = (fifo_count != '0) ? data_q[rd_ptr] : 32'h0;
    assign push       = (state == FILL) && mem_ack && !redirect;
    assign pop        = insn_take && insn_valid;

    always_comb begin
        state_next      = state;
        req_next        = mem_req;
        mem_addr_next   = mem_addr;
        rd_ptr_next     = rd_ptr;
        wr_ptr_next     = wr_ptr;
        count_next      = fifo_count;
        exp_addr_next   = exp_addr;
        fetch_addr_next = fetch_addr;

        if (redirect) begin
            rd_ptr_next     = '0;
            wr_ptr_next     = '0;
            count_next      = '0;
            exp_addr_next   = pc_in;
            fetch_addr_next = pc_in;
        end else begin
            if (push) begin
                wr_ptr_next     = wr_ptr + 1'b1;
                fetch_addr_next = fetch_addr + 32'd1;
            end
            if (pop) begin
                rd_ptr_next   = rd_ptr + 1'b1;
                exp_addr_next = exp_addr + 32'd1;
            end
            count_next = fifo_count + CW'(push) - CW'(pop);
        end

        // Every transition into FILL launches a request at the updated fetch address.
        case (state)
            IDLE: begin
                state_next    = FILL;
                req_next      = 1'b1;
                mem_addr_next = fetch_addr_next;
            end
            FILL: begin
                if (redirect && !mem_ack) begin
                    state_next = DISCARD;
                end else if (mem_ack) begin
                    if (count_next == CW'(DEPTH)) begin
                        state_next = FULL;
                        req_next   = 1'b0;
                    end else begin
                        req_next      = 1'b1;
                        mem_addr_next = fetch_addr_next;
                    end
                end
            end
            FULL: begin
                if (redirect || pop) begin
                    state_next    = FILL;
                    req_next      = 1'b1;
                    mem_addr_next = fetch_addr_next;
                end
            end
            DISCARD: begin
                if (mem_ack) begin
                    state_next    = FILL;
                    req_next      = 1'b1;
                    mem_addr_next = fetch_addr_next;
                end
            end
            default: begin
                state_next = IDLE;
                req_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            exp_addr   <= '0;
            fetch_addr <= '0;
        end else begin
            state      <= state_next;
            mem_req    <= req_next;
            mem_addr   <= mem_addr_next;
            rd_ptr     <= rd_ptr_next;
            wr_ptr     <= wr_ptr_next;
            fifo_count <= count_next;
            exp_addr   <= exp_addr_next;
            fetch_addr <= fetch_addr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_insn_prefetch_buffer.sv
// tb/tb_insn_prefetch_buffer.sv - self-checking bench for insn_prefetch_buffer
module tb_insn_prefetch_buffer;

    logic        clk;
    logic        rst = 1'b0;
    logic [31:0] pc_in = 32'h0;
    logic        insn_take = 1'b0;
    logic [31:0] insn_out;
    logic        insn_valid;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic [2:0]  fifo_count;

    int          errors = 0;
    int          checks = 0;
    int          takes = 0;
    int          mem_lat = 0;
    int          mem_wait = 0;
    bit          mem_en = 1'b0;
    bit          inject_ack = 1'b0;
    bit          consumed = 1'b0;
    logic [31:0] sb [$];

    insn_prefetch_buffer #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .insn_take  (insn_take),
        .insn_out   (insn_out),
        .insn_valid (insn_valid),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .fifo_count (fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory: acks after mem_lat waiting cycles, data = 0xA000_0000 + address.
    always @(negedge clk) begin
        if (mem_ack) mem_wait = 0;
        if (inject_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'hDEAD_BEEF;
        end else if (rst && mem_req && mem_en) begin
            if (mem_wait >= mem_lat) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hA000_0000 + mem_addr;
            end else begin
                mem_ack  = 1'b0;
                mem_wait = mem_wait + 1;
            end
        end else begin
            mem_ack  = 1'b0;
            mem_wait = 0;
        end
    end

    task automatic set_pc(input logic [31:0] pc);
        pc_in = pc;
        sb.delete();
        sb.push_back(32'hA000_0000 + pc);
    endtask

    task automatic sample();
        logic [31:0] want;
        if (insn_valid && insn_take) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_empty: insn_out=%h with no expected word", insn_out);
            end else begin
                want = sb.pop_front();
                if (insn_out !== want) begin
                    errors++;
                    $display("FAIL take_data: got %h want %h (pc %h)", insn_out, want, pc_in);
                end
            end
            consumed = 1'b1;
            takes++;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (consumed) begin
            consumed = 1'b0;
            set_pc(pc_in + 32'd1);
        end
        #1;
        sample();
    endtask

    task automatic do_reset(input logic [31:0] pc, input logic take, input int lat);
        rst        = 1'b0;
        insn_take  = take;
        mem_lat    = lat;
        mem_en     = 1'b1;
        inject_ack = 1'b0;
        consumed   = 1'b0;
        takes      = 0;
        set_pc(pc);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
        checks++; if (insn_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", insn_valid); end
        checks++; if (insn_out !== 32'h0) begin errors++; $display("FAIL rst_out: got %h want 0", insn_out); end
    endtask

    task automatic test_stream();
        do_reset(32'h0, 1'b1, 0);
        for (int i = 0; i < 24; i++) begin
            cycle();
            if (i == 0) begin
                checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL stream_first_addr: got %h want 0", mem_addr); end
                checks++; if (insn_valid !== 1'b0) begin errors++; $display("FAIL stream_first_valid: got %b want 0", insn_valid); end
            end else begin
                checks++; if (insn_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", i, insn_valid); end
                checks++; if (mem_addr !== pc_in + 32'd1) begin errors++; $display("FAIL stream_addr[%0d]: got %h want %h", i, mem_addr, pc_in + 32'd1); end
                checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL stream_count[%0d]: got %0d want 1", i, fifo_count); end
            end
        end
        checks++; if (takes !== 23) begin errors++; $display("FAIL stream_takes: got %0d want 23", takes); end
        insn_take = 1'b0;
    endtask

    task automatic test_full();
        int acks;
        acks = 0;
        do_reset(32'h0, 1'b0, 0);
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (mem_ack) acks++;
        end
        checks++; if (acks !== 4) begin errors++; $display("FAIL full_acks: got %0d want 4", acks); end
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", fifo_count); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL full_req: got %b want 0", mem_req); end
        insn_take = 1'b1;
        sample();
        @(posedge clk);
        #1;
        insn_take = 1'b0;
        consumed  = 1'b0;
        set_pc(32'h1);
        #1;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL full_pop_req: got %b want 1", mem_req); end
        checks++; if (mem_addr !== 32'h4) begin errors++; $display("FAIL full_pop_addr: got %h want 4", mem_addr); end
        checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL full_pop_count: got %0d want 3", fifo_count); end
        checks++; if (insn_out !== 32'hA000_0001) begin errors++; $display("FAIL full_pop_out: got %h want a0000001", insn_out); end
    endtask

    task automatic test_redirect();
        do_reset(32'hE, 1'b0, 0);
        repeat (6) cycle();
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL redir_pre_count: got %0d want 4", fifo_count); end
        checks++; if (insn_out !== 32'hA000_000E) begin errors++; $display("FAIL redir_pre_out: got %h want a000000e", insn_out); end
        mem_lat = 2;
        set_pc(32'h132);
        #1;
        checks++; if (insn_valid !== 1'b0) begin errors++; $display("FAIL redir_now_valid: got %b want 0", insn_valid); end
        cycle();
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL redir_count: got %0d want 0", fifo_count); end
        checks++; if (mem_addr !== 32'h132) begin errors++; $display("FAIL redir_addr: got %h want 132", mem_addr); end
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL redir_req: got %b want 1", mem_req); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (insn_valid !== 1'b0) begin errors++; $display("FAIL redir_wait_valid[%0d]: got %b want 0", i, insn_valid); end
            cycle();
        end
        checks++; if (insn_valid !== 1'b1) begin errors++; $display("FAIL redir_arrive_valid: got %b want 1", insn_valid); end
        checks++; if (insn_out !== 32'hA000_0132) begin errors++; $display("FAIL redir_arrive_out: got %h want a0000132", insn_out); end
    endtask

    task automatic test_discard();
        do_reset(32'h5, 1'b0, 3);
        cycle();
        checks++; if (mem_addr !== 32'h5) begin errors++; $display("FAIL disc_first_addr: got %h want 5", mem_addr); end
        set_pc(32'h132);
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++; if (mem_addr !== 32'h5) begin errors++; $display("FAIL disc_hold_addr[%0d]: got %h want 5", i, mem_addr); end
            checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL disc_hold_req[%0d]: got %b want 1", i, mem_req); end
        end
        cycle();
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL disc_count: got %0d want 0", fifo_count); end
        checks++; if (mem_addr !== 32'h132) begin errors++; $display("FAIL disc_next_addr: got %h want 132", mem_addr); end
        checks++; if (insn_valid !== 1'b0) begin errors++; $display("FAIL disc_valid: got %b want 0", insn_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset(32'h0, 1'b0, 0);
        repeat (4) cycle();
        checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL b2b_pre_count: got %0d want 3", fifo_count); end
        insn_take = 1'b1;
        sample();
        cycle();
        insn_take = 1'b0;
        consumed  = 1'b0;
        checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL b2b_count: got %0d want 3", fifo_count); end
        checks++; if (mem_addr !== 32'h4) begin errors++; $display("FAIL b2b_addr: got %h want 4", mem_addr); end
    endtask

    task automatic test_wrap();
        do_reset(32'hFFFF_FFFF, 1'b0, 0);
        cycle();
        checks++; if (mem_addr !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_first_addr: got %h want ffffffff", mem_addr); end
        insn_take = 1'b1;
        cycle();
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h want 0", mem_addr); end
        cycle();
        checks++; if (pc_in !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h want 0", pc_in); end
        checks++; if (mem_addr !== 32'h1) begin errors++; $display("FAIL wrap_next_addr: got %h want 1", mem_addr); end
        checks++; if (takes !== 2) begin errors++; $display("FAIL wrap_takes: got %0d want 2", takes); end
        insn_take = 1'b0;
        consumed  = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset(32'h0, 1'b0, 0);
        repeat (3) cycle();
        checks++; if (fifo_count !== 3'd2 || mem_req !== 1'b1) begin errors++; $display("FAIL arst_pre: got count %0d req %b want 2 1", fifo_count, mem_req); end
        #2 rst = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL arst_req: got %b want 0", mem_req); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL arst_count: got %0d want 0", fifo_count); end
        checks++; if (insn_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b want 0", insn_valid); end
        @(posedge clk);
        #1;
        rst        = 1'b1;
        inject_ack = 1'b1;
        @(posedge clk);
        #1;
        inject_ack = 1'b0;
        #1;
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL late_ack_count: got %0d want 0", fifo_count); end
        checks++; if (mem_addr !== 32'h0 || mem_req !== 1'b1) begin errors++; $display("FAIL late_ack_req: got addr %h req %b want 0 1", mem_addr, mem_req); end
        cycle();
        checks++; if (insn_out !== 32'hA000_0000) begin errors++; $display("FAIL late_ack_out: got %h want a0000000", insn_out); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_discard();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
